// File: rtl/cmp_pkg.sv
// Shared definitions for the comparison-result tracker.
//   - Outcome codes as produced by the upstream 8-bit comparator (one-hot,
//     000 = comparator has not produced a result yet).
//   - FSM state encoding for the run tracker.
//   - Helper mapping a legal outcome code onto its RUN_x state.
package cmp_pkg;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b100;

  // Streak output is 4 bits wide and saturates at its maximum.
  localparam logic [3:0] STREAK_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_GT = 2'd1,
    RUN_EQ = 2'd2,
    RUN_LT = 2'd3
  } state_e;

  // Only meaningful for the three legal one-hot codes; anything else maps to
  // IDLE so the caller must qualify with a legality check.
  function automatic state_e res2state(input logic [2:0] r);
    case (r)
      RES_GT:  return RUN_GT;
      RES_EQ:  return RUN_EQ;
      RES_LT:  return RUN_LT;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cmp_outcome_counter.sv
// Single outcome counter used once per comparison result (GT/EQ/LT).
// Build option: CMP_TRACK_SAT_EN -- when defined the counter sticks at
// 2^CNT_W-1, otherwise it wraps back to 0.
// Ports:
//   clk  : clock, rising edge
//   clr  : synchronous clear (has priority over en)
//   en   : count one event this cycle
//   cnt  : current count (registered)
module cmp_outcome_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
`ifdef CMP_TRACK_SAT_EN
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`else
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cmp_result_tracker.sv
// Tracks a stream of comparator outcomes: per-outcome counters, the length
// of the current run of identical outcomes, a one-shot pulse when the run
// reaches STREAK_LEN, and a sticky error for illegal (non-one-hot) codes.
// All outputs are registered: one cycle of latency after the sample.
// Build option: CMP_TRACK_SAT_EN selects saturating (defined) or wrapping
// (undefined) outcome counters.
// Ports:
//   Clk       : clock, rising edge
//   nReset    : synchronous active-low reset (overrides everything)
//   InValid   : R holds a new outcome this cycle
//   R         : outcome code, 100=GT 010=EQ 001=LT 000=no result
//   Clr       : synchronous clear of counters, streak, error; FSM -> IDLE
//   GtCnt/EqCnt/LtCnt : accumulated counts
//   Streak    : length of the current run (saturates at 15)
//   StreakHit : one-cycle pulse when Streak steps STREAK_LEN-1 -> STREAK_LEN
//   Err       : sticky illegal-code flag
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             InValid,
  input  logic [2:0]       R,
  input  logic             Clr,
  output logic [CNT_W-1:0] GtCnt,
  output logic [CNT_W-1:0] EqCnt,
  output logic [CNT_W-1:0] LtCnt,
  output logic [3:0]       Streak,
  output logic             StreakHit,
  output logic             Err
);

  localparam logic [3:0] STREAK_TGT = 4'(STREAK_LEN);
  localparam logic [3:0] STREAK_PRE = 4'(STREAK_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       hit_q, hit_d;
  logic       err_q, err_d;

  logic code_legal, smp_legal, smp_illegal, clr_all;
  logic inc_gt, inc_eq, inc_lt;

  assign code_legal  = (R == RES_GT) || (R == RES_EQ) || (R == RES_LT);
  assign smp_legal   = InValid && code_legal;
  // 000 is the comparator's reset value, not an error.
  assign smp_illegal = InValid && !code_legal && (R != RES_NONE);
  assign clr_all     = !nReset || Clr;

  // Next state: clear wins over any sample taken in the same cycle.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    hit_d    = 1'b0;
    err_d    = err_q;
    if (clr_all) begin
      state_d  = IDLE;
      streak_d = '0;
      err_d    = 1'b0;
    end else if (smp_illegal) begin
      err_d = 1'b1;
    end else if (smp_legal) begin
      state_d = res2state(R);
      if (res2state(R) == state_q)
        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
      else
        streak_d = 4'd1;
      // Pulse only on the crossing, never while the run keeps going.
      hit_d = (streak_q == STREAK_PRE) && (streak_d == STREAK_TGT);
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
    end
  end

  assign inc_gt = smp_legal && (R == RES_GT);
  assign inc_eq = smp_legal && (R == RES_EQ);
  assign inc_lt = smp_legal && (R == RES_LT);

  cmp_outcome_counter #(.CNT_W(CNT_W)) u_cnt_gt (
    .clk(Clk), .clr(clr_all), .en(inc_gt), .cnt(GtCnt)
  );
  cmp_outcome_counter #(.CNT_W(CNT_W)) u_cnt_eq (
    .clk(Clk), .clr(clr_all), .en(inc_eq), .cnt(EqCnt)
  );
  cmp_outcome_counter #(.CNT_W(CNT_W)) u_cnt_lt (
    .clk(Clk), .clr(clr_all), .en(inc_lt), .cnt(LtCnt)
  );

  assign Streak    = streak_q;
  assign StreakHit = hit_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Scoreboard bench for cmp_result_tracker (CNT_W=8, STREAK_LEN=4).
// Each driven cycle pushes the model's expected outputs; the observed DUT
// outputs one edge later are pushed alongside and compared by each test.
module tb_cmp_result_tracker;

  localparam int CW = 8;
  localparam int SL = 4;

  typedef struct packed {
    logic [CW-1:0] gt;
    logic [CW-1:0] eq;
    logic [CW-1:0] lt;
    logic [3:0]    streak;
    logic          hit;
    logic          err;
  } rec_t;

  logic          Clk = 1'b0;
  logic          nReset = 1'b0;
  logic          InValid = 1'b0;
  logic [2:0]    R = 3'b000;
  logic          Clr = 1'b0;
  logic [CW-1:0] GtCnt, EqCnt, LtCnt;
  logic [3:0]    Streak;
  logic          StreakHit, Err;

  int checks = 0;
  int failures = 0;

  rec_t m;
  int   m_st;
  rec_t exp_q[$];
  rec_t obs_q[$];

  cmp_result_tracker #(.CNT_W(CW), .STREAK_LEN(SL)) dut (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .R(R), .Clr(Clr),
    .GtCnt(GtCnt), .EqCnt(EqCnt), .LtCnt(LtCnt),
    .Streak(Streak), .StreakHit(StreakHit), .Err(Err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
`ifdef CMP_TRACK_SAT_EN
    return (x == {CW{1'b1}}) ? x : x + CW'(1);
`else
    return x + CW'(1);
`endif
  endfunction

  function automatic string fmt(input rec_t x);
    return $sformatf("gt=%0d eq=%0d lt=%0d streak=%0d hit=%0b err=%0b",
                     x.gt, x.eq, x.lt, x.streak, x.hit, x.err);
  endfunction

  // Drive one cycle, advance the model, record expected and observed.
  task automatic step(input logic inv, input logic [2:0] r,
                      input logic clr, input logic rst);
    logic [3:0] old;
    int k;
    InValid = inv; R = r; Clr = clr; nReset = !rst;
    old = m.streak;
    m.hit = 1'b0;
    if (rst || clr) begin
      m = '0; m_st = 0;
    end else if (inv) begin
      k = (r == 3'b100) ? 1 : (r == 3'b010) ? 2 : (r == 3'b001) ? 3 :
          (r == 3'b000) ? 0 : -1;
      if (k < 0) m.err = 1'b1;
      else if (k > 0) begin
        m.streak = (k == m_st) ? ((old == 4'd15) ? 4'd15 : old + 4'd1) : 4'd1;
        m_st = k;
        m.hit = (old == 4'(SL - 1)) && (m.streak == 4'(SL));
        if (k == 1) m.gt = inc(m.gt);
        if (k == 2) m.eq = inc(m.eq);
        if (k == 3) m.lt = inc(m.lt);
      end
    end
    exp_q.push_back(m);
    @(posedge Clk); #1;
    obs_q.push_back({GtCnt, EqCnt, LtCnt, Streak, StreakHit, Err});
    InValid = 1'b0; Clr = 1'b0; R = 3'b000;
  endtask

  task automatic test_reset();
    rec_t e, o;
    step(1'b1, 3'b100, 1'b1, 1'b1);
    step(1'b1, 3'b110, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e || o !== rec_t'('0)) begin
        failures++; $display("FAIL reset: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_basic();
    rec_t e, o;
    step(1'b1, 3'b100, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b0, 3'b100, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL basic: got %s want %s", fmt(o), fmt(e));
      end
    end
    checks++;
    if ({GtCnt, EqCnt, LtCnt, Streak, Err} !== {8'd2, 8'd1, 8'd1, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL basic_totals: got gt=%0d eq=%0d lt=%0d streak=%0d err=%0b want 2 1 1 1 0",
               GtCnt, EqCnt, LtCnt, Streak, Err);
    end
  endtask

  task automatic test_streak();
    rec_t e, o;
    int pulses;
    pulses = 0;
    step(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b0, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit) pulses++;
      if (o !== e) begin
        failures++; $display("FAIL streak: got %s want %s", fmt(o), fmt(e));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL streak_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_illegal();
    rec_t e, o;
    step(1'b1, 3'b110, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    step(1'b1, 3'b011, 1'b0, 1'b0);
    step(1'b1, 3'b111, 1'b0, 1'b0);
    step(1'b1, 3'b101, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b1, 1'b0);
    step(1'b1, 3'b110, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL illegal: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_none();
    rec_t e, o;
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL none: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_clr_priority();
    rec_t e, o;
    step(1'b1, 3'b100, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b1, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL clr_priority: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_midrun();
    rec_t e, o;
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b001, 1'b0, 1'b1);
    step(1'b1, 3'b001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL reset_midrun: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_saturate();
    rec_t e, o;
    logic [CW-1:0] want;
`ifdef CMP_TRACK_SAT_EN
    want = 8'd255;
`else
    want = 8'd4;
`endif
    step(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 3'b001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL saturate: got %s want %s", fmt(o), fmt(e));
      end
    end
    checks++;
    if (LtCnt !== want) begin
      failures++; $display("FAIL saturate_final: got lt=%0d want %0d", LtCnt, want);
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 20) == 0, $urandom_range(0, 60) == 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL back_to_back: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    m = '0; m_st = 0;
    test_reset();
    test_basic();
    test_streak();
    test_illegal();
    test_none();
    test_clr_priority();
    test_reset_midrun();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
CMP_RESULT_TRACKER -- requirements
Module: cmp_result_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each outcome counter.
REQ-002 SHALL have parameter STREAK_LEN, default 4: number of consecutive identical outcomes that raises StreakHit (legal range 2..15).
REQ-003 SHALL have port Clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port nReset  input  1: synchronous active-low reset, sampled on rising Clk.
REQ-005 SHALL have port InValid  input  1: R carries a new comparison outcome this cycle.
REQ-006 SHALL have port R  input  3: outcome code from the upstream 8-bit comparator; 100 = A>B, 010 = A==B, 001 = A<B.
REQ-007 SHALL have port Clr  input  1: synchronous clear of counters, streak and error.
REQ-008 SHALL have ports GtCnt, EqCnt, LtCnt  output  CNT_W each: accumulated counts per outcome.
REQ-009 SHALL have port Streak  output  4: length of current run of identical outcomes.
REQ-010 SHALL have port StreakHit  output  1: one-cycle pulse when Streak reaches STREAK_LEN.
REQ-011 SHALL have port Err  output  1: sticky flag for an illegal R code.

Function
REQ-012 SHALL sample R only when InValid=1; when InValid=0 all state holds and StreakHit=0.
REQ-013 SHALL treat R=000 with InValid=1 as "no result" (the upstream reset value): counters, streak and Err unchanged.
REQ-014 SHALL treat any other non-one-hot R (011, 101, 110, 111) with InValid=1 as illegal: set Err, leave counters and streak unchanged.
REQ-015 SHALL implement FSM states IDLE, RUN_GT, RUN_EQ, RUN_LT: IDLE -> RUN_x on the first legal outcome x; RUN_x -> RUN_x on x (Streak+1); RUN_x -> RUN_y on y≠x (Streak=1).
REQ-016 SHALL increment the matching counter one cycle after the accepted sample, giving one-cycle latency for all outputs.
REQ-017 SHALL saturate Streak at 15; StreakHit SHALL pulse only on the transition Streak: STREAK_LEN-1 -> STREAK_LEN, not while the run continues.
REQ-018 SHALL give Clr priority over a simultaneous valid sample; the sample is discarded and FSM returns to IDLE.
REQ-019 SHALL keep Err set until Clr or reset.

Reset
REQ-020 SHALL, on nReset=0 at a rising Clk edge, force state IDLE, all counters 0, Streak 0, StreakHit 0, Err 0, overriding Clr and InValid.
REQ-021 SHALL discard any run in progress when reset is asserted mid-operation; the first legal outcome after release starts Streak=1.

Configuration
REQ-022 SHALL honour macro CMP_TRACK_SAT_EN: when defined, counters saturate at 2^CNT_W-1; when undefined, counters wrap to 0 after 2^CNT_W-1.

Structure
REQ-023 SHALL take outcome codes (RES_GT, RES_EQ, RES_LT, RES_NONE) and the FSM state encoding from shared package cmp_pkg.
REQ-024 SHALL instantiate three copies of sub-module cmp_outcome_counter (enable, clear, saturate-or-wrap per CMP_TRACK_SAT_EN).

Verification
REQ-025 SHALL cover: reset, then InValid=1 with R=100,100,010,001 -> GtCnt=2, EqCnt=1, LtCnt=1, Streak=1, Err=0.
REQ-026 SHALL cover: 4 consecutive R=010 with STREAK_LEN=4 -> StreakHit pulses exactly once, in the cycle after the 4th sample; 5th R=010 -> Streak=5, no pulse.
REQ-027 SHALL cover: R=110 with InValid=1 -> Err=1, counters unchanged; later R=100 counts normally; Clr -> Err=0.
REQ-028 SHALL cover: 260 samples of R=001 with CNT_W=8 -> LtCnt=255 with CMP_TRACK_SAT_EN defined, LtCnt=4 without it.
REQ-029 SHALL cover: Clr and InValid (R=100) in the same cycle -> GtCnt=0, FSM IDLE; nReset=0 mid-run of 3 -> all outputs 0 on the next edge.
REQ-030 SHALL cover: InValid=1 with R=000 -> no output change.
